serv_mdu_iter: RTL and testbench
================================

# serv_mdu_iter

Iterative RV32M multiply/divide unit on the extension side of the SERV state/control stage. It consumes the held-high `mdu_valid` request, funct3 and the two parallel source operands. It computes MUL/MULH/MULHSU/MULHU in a 32-cycle shift-add loop and DIV/DIVU/REM/REMU in a 32-cycle restoring-division loop. It returns a 32-bit result with a one-cycle `ready` strobe that the state stage uses to raise its RF write request.

## Interface
- No parameters: the datapath is fixed at 32 bits.
- `i_clk`  in  1  core clock
- `i_rst`  in  1  asynchronous, active-high reset
- `i_mdu_valid`  in  1  request level; held high by the state stage until after `o_mdu_ready`
- `i_mdu_op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `i_mdu_rs1`  in  32  operand A (dividend); sampled only at accept
- `i_mdu_rs2`  in  32  operand B (divisor); sampled only at accept
- `o_mdu_rd`  out  32  result; valid from `o_mdu_ready` until the next accept
- `o_mdu_ready`  out  1  single-cycle completion strobe

## Operation
- **States:** IDLE, RUN, FIX, DONE, HOLD.
- **Accept:** `i_mdu_valid` high in IDLE at edge T.
  - Latch op, sign flags and operand magnitudes.
  - Signed operands: rs1 for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
  - Clear the 5-bit counter.
- **Accumulator:** 64-bit, shared. Multiply uses it as {hi, lo}; divide uses it as {rem, quot}.
- **RUN (multiply):** each cycle, if the current multiplier LSB is 1, add the multiplicand to hi, then shift the accumulator right by one.
- **RUN (divide):** each cycle, shift {rem, quot} left by one. Trial-subtract the divisor from rem. If there is no borrow, commit the difference and set quot LSB.
- **Counter:** increments each RUN cycle. At 31 it wraps to 0 and the state goes to FIX.
- **FIX:** conditionally two's-complement negate, then go to DONE.
  - Multiply: negate the 64-bit product if the operand signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: takes the dividend's sign.
- **Result select:** MUL takes the low word; MULH/MULHSU/MULHU take the high word; DIV/DIVU take the quotient; REM/REMU take the remainder. The selection is registered into `o_mdu_rd` on entry to DONE.
- **Divide by zero:** detected at accept.
  - Skip RUN and FIX; load the result directly and go to DONE.
  - Quotient is 0xFFFFFFFF; remainder is rs1 unmodified.
- **Signed overflow** (0x80000000 / -1): no special path. The magnitude algorithm yields quotient 0x80000000 and remainder 0.
- **DONE:** `o_mdu_ready` = 1 for exactly one cycle, then go to HOLD.
- **HOLD:** stay while `i_mdu_valid` is 1; go to IDLE when it is 0. This prevents re-triggering on the still-high request.
- **Valid dropped mid-operation:** not legal, but tolerated. The unit completes, pulses ready, and HOLD exits immediately.

## Timing
- **Reset values:** state IDLE, counter 0, accumulator 0, `o_mdu_rd` = 0, `o_mdu_ready` = 0.
- **Reset mid-operation:** returns to IDLE asynchronously; no ready pulse.
- **Normal op:** accept at edge T; RUN edges T+1..T+32; FIX edge T+33. `o_mdu_ready` is high in the cycle after edge T+33, a latency of 34 cycles.
- **Divide by zero:** `o_mdu_ready` is high in the cycle after edge T, a latency of 1 cycle.
- **Ready source:** `o_mdu_ready` is decoded from state DONE only (registered state, no combinational path from inputs).
- **Back-to-back requests:** the minimum gap between two accepts is one IDLE cycle after valid falls.

## Configuration
- **`SERV_MDU_DIV_EN` defined:** full M extension as above.
- **`SERV_MDU_DIV_EN` undefined:**
  - Divider datapath and trial subtractor removed.
  - Ops with `i_mdu_op[2]` = 1 go IDLE→DONE on accept (latency 1) with `o_mdu_rd` = 0.
  - Multiply behaviour is unchanged.

## Structure
- **Package `serv_mdu_pkg`:**
  - funct3 encodings as localparams (OP_MUL … OP_REMU).
  - State encoding (IDLE, RUN, FIX, DONE, HOLD).
  - Counter terminal value 5'd31.
- **Sub-module `serv_mdu_cneg`:** width-parameterised conditional two's-complement negator. Instantiated for the operand magnitudes (32-bit) and for the FIX correction (64-bit product; 32-bit quotient and remainder).

## Test plan
- **MUL:** 7 × 0xFFFFFFFD → `o_mdu_rd` = 0xFFFFFFEB; ready 34 cycles after accept, high for exactly 1 cycle.
- **High-word multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- **Divide by zero:** DIVU 5 / 0 → 0xFFFFFFFF; REMU → 5; DIV 0xFFFFFFF9 / 0 → 0xFFFFFFFF. Ready 1 cycle after accept in every case.
- **Held request:** hold `i_mdu_valid` high 6 cycles past ready → no second ready and `o_mdu_rd` unchanged. Drop for 1 cycle, reassert with MULHU → new correct result.
- **Reset mid-operation:** assert `i_rst` at RUN count 10 → ready never pulses and `o_mdu_rd` = 0. A following MUL 3 × 4 returns 12. With `SERV_MDU_DIV_EN` undefined, DIV 10 / 2 → 0 after 1 cycle.

Source files
------------

// File: rtl/serv_mdu_pkg.sv
// serv_mdu_pkg: funct3 encodings, FSM states and loop terminal count for serv_mdu_iter
package serv_mdu_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam logic [4:0] CNT_LAST  = 5'd31;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIX, S_DONE, S_HOLD} state_t;
endpackage

// File: rtl/serv_mdu_cneg.sv
// serv_mdu_cneg: width-parameterised conditional two's-complement negator
module serv_mdu_cneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/serv_mdu_iter.sv
// serv_mdu_iter: iterative RV32M shift-add multiplier / restoring divider; divider built only with SERV_MDU_DIV_EN
module serv_mdu_iter
  import serv_mdu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mdu_valid,
  input  logic [2:0]  i_mdu_op,
  input  logic [31:0] i_mdu_rs1,
  input  logic [31:0] i_mdu_rs2,
  output logic [31:0] o_mdu_rd,
  output logic        o_mdu_ready
);
  state_t state, state_nxt;
  logic [4:0] cnt;
  logic [63:0] acc, acc_nxt, prod;
  logic [31:0] b_q, a_mag, b_mag, fast_rd, res_sel;
  logic [32:0] mul_sum;
  logic [2:0] op_q;
  logic s1_q, s2_q, sg1, sg2, fast;
  assign sg1 = i_mdu_op[2] ? ~i_mdu_op[0] : i_mdu_op[1] ^ i_mdu_op[0];
  assign sg2 = i_mdu_op[2] ? ~i_mdu_op[0] : i_mdu_op[1:0] == 2'b01;
  serv_mdu_cneg #(.W(32)) u_amag (.a(i_mdu_rs1), .neg(sg1 & i_mdu_rs1[31]), .y(a_mag));
  serv_mdu_cneg #(.W(32)) u_bmag (.a(i_mdu_rs2), .neg(sg2 & i_mdu_rs2[31]), .y(b_mag));
  serv_mdu_cneg #(.W(64)) u_prod (.a(acc), .neg(s1_q ^ s2_q), .y(prod));
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
`ifdef SERV_MDU_DIV_EN
  logic [31:0] diff, quot, rem;
  logic no_borrow;
  // acc[63:31] is the partial remainder after this cycle's left shift
  assign no_borrow = acc[63:31] >= {1'b0, b_q};
  assign diff = acc[62:31] - b_q;
  serv_mdu_cneg #(.W(32)) u_quot (.a(acc[31:0]), .neg(s1_q ^ s2_q), .y(quot));
  serv_mdu_cneg #(.W(32)) u_rem (.a(acc[63:32]), .neg(s1_q), .y(rem));
  assign fast = i_mdu_op[2] & ~|i_mdu_rs2;
  assign fast_rd = i_mdu_op[1] ? i_mdu_rs1 : 32'hFFFF_FFFF;
  assign acc_nxt = !op_q[2] ? {mul_sum, acc[31:1]} : no_borrow ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
  assign res_sel = op_q == OP_MUL ? prod[31:0] : !op_q[2] ? prod[63:32] : op_q[1] ? rem : quot;
`else
  assign fast = i_mdu_op[2];
  assign fast_rd = 32'd0;
  assign acc_nxt = {mul_sum, acc[31:1]};
  assign res_sel = op_q == OP_MUL ? prod[31:0] : prod[63:32];
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: state_nxt = i_mdu_valid ? (fast ? S_DONE : S_RUN) : S_IDLE;
      S_RUN:  state_nxt = cnt == CNT_LAST ? S_FIX : S_RUN;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_HOLD;
      S_HOLD: state_nxt = i_mdu_valid ? S_HOLD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb o_mdu_ready = state == S_DONE;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      cnt <= '0;
      acc <= '0;
      b_q <= '0;
      op_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      o_mdu_rd <= '0;
    end else if (state == S_IDLE && i_mdu_valid) begin
      op_q <= i_mdu_op;
      s1_q <= sg1 & i_mdu_rs1[31];
      s2_q <= sg2 & i_mdu_rs2[31];
      b_q <= b_mag;
      acc <= {32'd0, a_mag};
      cnt <= '0;
      if (fast) o_mdu_rd <= fast_rd;
    end else if (state == S_RUN) begin
      cnt <= cnt + 5'd1;
      acc <= acc_nxt;
    end else if (state == S_FIX) begin
      o_mdu_rd <= res_sel;
    end
endmodule

// File: tb/tb_serv_mdu_iter.sv
// tb_serv_mdu_iter: directed table, hand sequences and random ops checked against an arithmetic model
module tb_serv_mdu_iter;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, ready;
  logic [2:0] op = 3'd0;
  logic [31:0] rs1 = '0, rs2 = '0, rd;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[11];
  serv_mdu_iter dut (
    .i_clk(clk), .i_rst(rst), .i_mdu_valid(valid), .i_mdu_op(op),
    .i_mdu_rs1(rs1), .i_mdu_rs2(rs2), .o_mdu_rd(rd), .o_mdu_ready(ready)
  );
  always #5 clk = ~clk;
`ifdef SERV_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    if (f[2] && !DIV_EN) return 32'd0;
    ea = {{32{a[31] & (f == 3'd1 || f == 3'd2)}}, a};
    eb = {{32{b[31] & (f == 3'd1)}}, b};
    p = ea * eb;
    sa = a;
    sb = b;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] b);
    return f[2] && (!DIV_EN || b == 0) ? 1 : 34;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    logic [31:0] r;
    @(negedge clk);
    valid = 1'b1;
    op = f;
    rs1 = a;
    rs2 = b;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        rs1 = $urandom;
        rs2 = $urandom;
        op = 3'($urandom);
      end
    end while (!ready && n < 60);
    check($sformatf("lat op%0d %h %h", f, a, b), n, exp_lat(f, b));
    check($sformatf("rd op%0d %h %h", f, a, b), rd, exp);
    r = rd;
    @(posedge clk);
    #1;
    check($sformatf("pulse op%0d", f), {31'd0, ready}, 32'd0);
    check($sformatf("keep op%0d", f), rd, r);
    @(negedge clk);
    valid = 1'b0;
  endtask
  initial begin
    logic [2:0] f;
    logic [31:0] a, b, r;
    int pulses;
    vt[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB};
    vt[1]  = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000};
    vt[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[4]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD};
    vt[5]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF};
    vt[6]  = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000};
    vt[7]  = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0};
    vt[8]  = '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF};
    vt[9]  = '{3'd7, 32'd5,         32'd0,        32'd5};
    vt[10] = '{3'd4, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF};
    repeat (3) @(posedge clk);
    #1;
    check("reset rd", rd, 32'd0);
    check("reset ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    foreach (vt[i]) run_op(vt[i].op, vt[i].a, vt[i].b, (vt[i].op[2] && !DIV_EN) ? 32'd0 : vt[i].exp);
    // request held past ready must not retrigger
    @(negedge clk);
    valid = 1'b1;
    op = 3'd0;
    rs1 = 32'd1234;
    rs2 = 32'd5678;
    pulses = 0;
    for (int i = 0; i < 60 && !ready; i++) @(posedge clk) #1;
    check("held first rd", rd, 32'd7006652);
    r = rd;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
    end
    check("held pulses", pulses, 0);
    check("held rd", rd, r);
    @(negedge clk);
    valid = 1'b0;
    run_op(3'd3, 32'hDEADBEEF, 32'hCAFEF00D, model(3'd3, 32'hDEADBEEF, 32'hCAFEF00D));
    // async reset in the middle of the multiply loop
    @(negedge clk);
    valid = 1'b1;
    op = 3'd0;
    rs1 = 32'd99;
    rs2 = 32'd77;
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    valid = 1'b0;
    #1;
    check("midrst rd", rd, 32'd0);
    check("midrst ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
    end
    check("midrst pulses", pulses, 0);
    run_op(3'd0, 32'd3, 32'd4, 32'd12);
    run_op(3'd4, 32'd10, 32'd2, DIV_EN ? 32'd5 : 32'd0);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 9);
        3: a = -$urandom_range(0, 50);
        default: ;
      endcase
      run_op(f, a, b, model(f, a, b));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
